// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    StIdle,
    StPrep,
    StCalc,
    StFix,
    StDone
  } state_e;

  // Counter width for a WIDTH-bit bit index; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: yields the magnitude of an operand or applies a result sign.
module div_sign_fix #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = negate ? (~value + 1'b1) : value;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, with optional signed mode,
// divide-by-zero / overflow short cuts and an early exit when the divisor dominates.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          SIGNED_EN  = 1'b1,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CntW = clog2(WIDTH);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] dvd_mag_q, dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             eff_signed;
  logic [WIDTH-1:0] dvd_abs, dvs_abs, quo_fixed, rem_fixed;
  logic [WIDTH:0]   shifted;

  assign eff_signed = is_signed & SIGNED_EN;

  div_sign_fix #(.WIDTH(WIDTH)) u_dvd_abs (
    .value  (dividend_q),
    .negate (signed_q & dividend_q[WIDTH-1]),
    .result (dvd_abs)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_dvs_abs (
    .value  (divisor_q),
    .negate (signed_q & divisor_q[WIDTH-1]),
    .result (dvs_abs)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_quo_fix (
    .value  (quo_q),
    .negate (q_neg_q),
    .result (quo_fixed)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
    .value  (rem_q[WIDTH-1:0]),
    .negate (r_neg_q),
    .result (rem_fixed)
  );

  // Partial remainder shifted left with the next dividend bit, MSB first.
  assign shifted = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_mag_q[cnt_q]};

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    signed_d    = signed_q;
    dvd_mag_d   = dvd_mag_q;
    dvs_mag_d   = dvs_mag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          signed_d   = eff_signed;
          if (divisor == '0) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
          end else if (eff_signed && dividend == MinVal && divisor == '1) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            quotient_d  = MinVal;
            remainder_d = '0;
            dbz_d       = 1'b0;
            ovf_d       = 1'b1;
          end else begin
            state_d = StPrep;
          end
        end
      end

      StPrep: begin
        dvd_mag_d = dvd_abs;
        dvs_mag_d = dvs_abs;
        q_neg_d   = signed_q & (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
        r_neg_d   = signed_q & dividend_q[WIDTH-1];
        if (EARLY_EXIT && (dvs_abs > dvd_abs)) begin
          // Quotient is zero and the signed remainder is the dividend itself.
          state_d     = StDone;
          out_valid_d = 1'b1;
          quotient_d  = '0;
          remainder_d = dividend_q;
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
        end else begin
          state_d = StCalc;
          cnt_d   = CntW'(WIDTH - 1);
          rem_d   = '0;
          quo_d   = '0;
        end
      end

      StCalc: begin
        if (shifted >= {1'b0, dvs_mag_q}) begin
          rem_d = shifted - {1'b0, dvs_mag_q};
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end

      StFix: begin
        state_d     = StDone;
        out_valid_d = 1'b1;
        quotient_d  = quo_fixed;
        remainder_d = rem_fixed;
        dbz_d       = 1'b0;
        ovf_d       = 1'b0;
      end

      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      dividend_q  <= '0;
      divisor_q   <= '0;
      signed_q    <= 1'b0;
      dvd_mag_q   <= '0;
      dvs_mag_q   <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      signed_q    <= signed_d;
      dvd_mag_q   <= dvd_mag_d;
      dvs_mag_q   <= dvs_mag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider (WIDTH=8), with a second instance without early exit.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_valid_ne;
  logic       in_ready, in_ready_ne;
  logic [7:0] dividend, divisor;
  logic       is_signed;
  logic       out_valid, out_valid_ne;
  logic       out_ready;
  logic       ready_ne;
  logic [7:0] quotient, remainder, quotient_ne, remainder_ne;
  logic       div_by_zero, overflow, dbz_ne, ovf_ne;
  logic       busy, busy_ne;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1), .EARLY_EXIT(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .busy        (busy)
  );

  seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1), .EARLY_EXIT(1'b0)) dut_ne (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid_ne),
    .in_ready    (in_ready_ne),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid_ne),
    .out_ready   (ready_ne),
    .quotient    (quotient_ne),
    .remainder   (remainder_ne),
    .div_by_zero (dbz_ne),
    .overflow    (ovf_ne),
    .busy        (busy_ne)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output logic ov);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 8'h00) begin
      q  = 8'hFF;
      r  = a;
      dz = 1'b1;
    end else if (s && a == 8'h80 && b == 8'hFF) begin
      q  = 8'h80;
      r  = 8'h00;
      ov = 1'b1;
    end else if (s) begin
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      q  = 8'(sa / sb);
      r  = 8'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issues one operation on dut and returns its outputs and accept-to-out_valid latency.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dz, output logic ov, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    is_signed = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'h33;
    divisor  = 8'h44;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    ov = overflow;
  endtask

  initial begin
    vec_t       vecs[14];
    logic [7:0] q, r, eq, er;
    logic       dz, ov, edz, eov;
    int         lat, bad;

    vecs[0]  = '{8'd200, 8'd7,   1'b0, 8'd28,  8'd4,  1'b0, 1'b0, 11};
    vecs[1]  = '{8'h5A,  8'h00,  1'b0, 8'hFF,  8'h5A, 1'b1, 1'b0, 1};
    vecs[2]  = '{8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF, 1'b0, 1'b0, 11};
    vecs[3]  = '{8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01, 1'b0, 1'b0, 11};
    vecs[4]  = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00, 1'b0, 1'b1, 1};
    vecs[5]  = '{8'd5,   8'd9,   1'b0, 8'd0,   8'd5,  1'b0, 1'b0, 2};
    vecs[6]  = '{8'd100, 8'd10,  1'b0, 8'd10,  8'd0,  1'b0, 1'b0, 11};
    vecs[7]  = '{8'h80,  8'hFF,  1'b0, 8'h00,  8'h80, 1'b0, 1'b0, 2};
    vecs[8]  = '{8'hFB,  8'h09,  1'b1, 8'h00,  8'hFB, 1'b0, 1'b0, 2};
    vecs[9]  = '{8'hFF,  8'h01,  1'b0, 8'hFF,  8'h00, 1'b0, 1'b0, 11};
    vecs[10] = '{8'hFD,  8'h00,  1'b1, 8'hFF,  8'hFD, 1'b1, 1'b0, 1};
    vecs[11] = '{8'd9,   8'd9,   1'b0, 8'd1,   8'd0,  1'b0, 1'b0, 11};
    vecs[12] = '{8'h80,  8'h02,  1'b1, 8'hC0,  8'h00, 1'b0, 1'b0, 11};
    vecs[13] = '{8'h80,  8'hFF,  1'b0, 8'h00,  8'h80, 1'b0, 1'b0, 2};

    reset       = 1'b1;
    in_valid    = 1'b0;
    in_valid_ne = 1'b0;
    out_ready   = 1'b1;
    ready_ne    = 1'b1;
    dividend    = '0;
    divisor     = '0;
    is_signed   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, q, r, dz, ov, lat);
      check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("vec%0d_r", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d_flags", i), {30'd0, dz, ov}, {30'd0, vecs[i].dz, vecs[i].ov});
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Same 5/9 without early exit: full iteration latency.
    @(negedge clk);
    dividend    = 8'd5;
    divisor     = 8'd9;
    is_signed   = 1'b0;
    in_valid_ne = 1'b1;
    @(posedge clk);
    #1;
    in_valid_ne = 1'b0;
    lat = 1;
    while (!out_valid_ne && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("noee_lat", 32'(lat), 32'd11);
    check("noee_q", 32'(quotient_ne), 32'd0);
    check("noee_r", 32'(remainder_ne), 32'd5);

    // Backpressure: hold the result in DONE while new operands wait.
    out_ready = 1'b0;
    do_op(8'd200, 8'd7, 1'b0, q, r, dz, ov, lat);
    check("bp_first_q", 32'(q), 32'd28);
    @(negedge clk);
    dividend  = 8'd100;
    divisor   = 8'd10;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (!out_valid || quotient != 8'd28 || remainder != 8'd4 || in_ready) bad++;
    end
    check("bp_hold_bad_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_queued_accept_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_queued_lat", 32'(lat), 32'd11);
    check("bp_queued_q", 32'(quotient), 32'd10);

    // Reset in the middle of CALC aborts without a result.
    @(negedge clk);
    dividend  = 8'd200;
    divisor   = 8'd7;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_outputs", {16'd0, quotient, remainder}, 32'd0);
    reset = 1'b0;
    do_op(8'd100, 8'd10, 1'b0, q, r, dz, ov, lat);
    check("midrst_fresh_q", 32'(q), 32'd10);
    check("midrst_fresh_r", 32'(r), 32'd0);
    check("midrst_fresh_lat", 32'(lat), 32'd11);

    // Random sweep against a behavioural model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a, b;
      logic       s;
      a = 8'($urandom);
      b = (i % 37 == 0) ? 8'h00 : 8'($urandom);
      s = 1'($urandom);
      if (i % 53 == 0) begin
        a = 8'h80;
        b = 8'hFF;
      end
      model(a, b, s, eq, er, edz, eov);
      do_op(a, b, s, q, r, dz, ov, lat);
      check($sformatf("rnd%0d_%0h_%0h_s%0d_qr", i, a, b, s), {16'd0, q, r}, {16'd0, eq, er});
      check($sformatf("rnd%0d_flags", i), {30'd0, dz, ov}, {30'd0, edz, eov});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
